// File: rtl/result_scoreboard_if.sv
// result_scoreboard_if: table-load, run-control, sample and report signals of the result scoreboard
interface result_scoreboard_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 32
);
    localparam int IDX_W = $clog2(DEPTH);
    logic             load_en;
    logic [IDX_W-1:0] load_addr;
    logic [WIDTH-1:0] load_data;
    logic [WIDTH-1:0] load_mask;
    logic [IDX_W:0]   num_checks;
    logic             start;
    logic             result_valid;
    logic [WIDTH-1:0] result;
    logic             busy;
    logic             done;
    logic [IDX_W:0]   pass_count;
    logic [IDX_W:0]   fail_count;
    logic             first_fail_valid;
    logic [IDX_W-1:0] first_fail_idx;
    logic             mismatch;
    modport master (
        output load_en, load_addr, load_data, load_mask, num_checks, start, result_valid, result,
        input  busy, done, pass_count, fail_count, first_fail_valid, first_fail_idx, mismatch
    );
    modport slave (
        input  load_en, load_addr, load_data, load_mask, num_checks, start, result_valid, result,
        output busy, done, pass_count, fail_count, first_fail_valid, first_fail_idx, mismatch
    );
endinterface

// File: rtl/result_scoreboard.sv
// result_scoreboard: in-order masked compare of a valid-gated result stream against a loadable expected table
module result_scoreboard #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 32
) (
    input logic clk,
    input logic reset,
    result_scoreboard_if.slave bus
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int CW = IDX_W + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
    state_e           state_q, state_d;
    logic [WIDTH-1:0] exp_q  [DEPTH];
    logic [WIDTH-1:0] mask_q [DEPTH];
    logic [IDX_W-1:0] idx_q, idx_d, ffi_q, ffi_d;
    logic [CW-1:0]    n_q, n_d, pass_q, pass_d, fail_q, fail_d, n_clamp;
    logic             ffv_q, ffv_d, mm_q, mm_d, hit, last;
    assign n_clamp = bus.num_checks > DEPTH_C ? DEPTH_C : bus.num_checks;
    assign hit     = ((bus.result ^ exp_q[idx_q]) & mask_q[idx_q]) == '0;
    assign last    = {1'b0, idx_q} == n_q - CW'(1);
    // Table has no reset so its contents survive a mid-run abort; writes are blocked during RUN.
    always_ff @(posedge clk) begin
        if (bus.load_en && state_q != RUN) begin
            exp_q[bus.load_addr]  <= bus.load_data;
            mask_q[bus.load_addr] <= bus.load_mask;
        end
    end
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        n_d     = n_q;
        pass_d  = pass_q;
        fail_d  = fail_q;
        ffv_d   = ffv_q;
        ffi_d   = ffi_q;
        mm_d    = 1'b0;
        if (state_q != RUN) begin
            if (bus.start) begin
                n_d     = n_clamp;
                idx_d   = '0;
                pass_d  = '0;
                fail_d  = '0;
                ffv_d   = 1'b0;
                ffi_d   = '0;
                state_d = n_clamp == '0 ? DONE : RUN;
            end
        end else if (bus.result_valid) begin
            pass_d  = hit ? pass_q + CW'(1) : pass_q;
            fail_d  = hit ? fail_q : fail_q + CW'(1);
            mm_d    = !hit;
            ffv_d   = ffv_q | !hit;
            ffi_d   = (!hit && !ffv_q) ? idx_q : ffi_q;
            idx_d   = idx_q + IDX_W'(1);
            state_d = last ? DONE : RUN;
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            n_q     <= '0;
            pass_q  <= '0;
            fail_q  <= '0;
            ffv_q   <= 1'b0;
            ffi_q   <= '0;
            mm_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            n_q     <= n_d;
            pass_q  <= pass_d;
            fail_q  <= fail_d;
            ffv_q   <= ffv_d;
            ffi_q   <= ffi_d;
            mm_q    <= mm_d;
        end
    end
    assign bus.busy             = state_q == RUN;
    assign bus.done             = state_q == DONE;
    assign bus.pass_count       = pass_q;
    assign bus.fail_count       = fail_q;
    assign bus.first_fail_valid = ffv_q;
    assign bus.first_fail_idx   = ffi_q;
    assign bus.mismatch         = mm_q;
endmodule

// File: tb/tb_result_scoreboard.sv
// tb_result_scoreboard: directed stimulus with queued expectations checked by per-sample and per-run monitors
module tb_result_scoreboard;
    typedef struct packed {
        logic [5:0] p;
        logic [5:0] f;
        logic       v;
        logic [4:0] i;
    } sum_t;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int checks = 0;
    int errors = 0;
    logic [31:0] tab [32];
    logic [1:0] mm_q [$];
    sum_t sum_q [$];
    logic done_prev = 1'b0;
    result_scoreboard_if #(.WIDTH(32), .DEPTH(32)) bus ();
    result_scoreboard #(.WIDTH(32), .DEPTH(32)) dut (.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;
    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s got=%h expected=%h t=%0t", nm, a, e, $time);
        end
    endtask
    // Per-edge monitor: every consumed sample pops its expected mismatch/last flags.
    always @(posedge clk) begin
        logic consumed;
        logic [1:0] e;
        consumed = !reset && bus.busy && bus.result_valid;
        #1;
        if (consumed) begin
            if (mm_q.size() == 0) chk("sample_queue_empty", 1, 0);
            else begin
                e = mm_q.pop_front();
                chk("mismatch", bus.mismatch, e[1]);
                chk("done_at_sample", bus.done, e[0]);
                chk("busy_at_sample", bus.busy, !e[0]);
            end
        end else chk("mismatch_idle", bus.mismatch, 0);
    end
    // Per-run monitor: completion of a run pops the expected final counts.
    always @(posedge clk) begin
        sum_t s;
        #2;
        if (bus.done && !done_prev && !reset) begin
            if (sum_q.size() == 0) chk("summary_queue_empty", 1, 0);
            else begin
                s = sum_q.pop_front();
                chk("pass_count", bus.pass_count, s.p);
                chk("fail_count", bus.fail_count, s.f);
                chk("ff_valid", bus.first_fail_valid, s.v);
                chk("ff_idx", bus.first_fail_idx, s.i);
            end
        end
        done_prev = bus.done;
    end
    task automatic load(input int a, input logic [31:0] d, input logic [31:0] m);
        bus.load_en = 1'b1;
        bus.load_addr = 5'(a);
        bus.load_data = d;
        bus.load_mask = m;
        @(negedge clk);
        bus.load_en = 1'b0;
    endtask
    task automatic go(input int n);
        bus.start = 1'b1;
        bus.num_checks = 6'(n);
        @(negedge clk);
        bus.start = 1'b0;
    endtask
    task automatic sample(input logic [31:0] r, input logic mm, input logic lst);
        bus.result_valid = 1'b1;
        bus.result = r;
        mm_q.push_back({mm, lst});
        @(negedge clk);
        bus.result_valid = 1'b0;
    endtask
    task automatic wait_done();
        int t = 0;
        while (!bus.done && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("done_timeout", bus.done, 1);
    endtask
    task automatic exp_sum(input int p, input int f, input logic v, input int i);
        sum_q.push_back('{p: 6'(p), f: 6'(f), v: v, i: 5'(i)});
    endtask
    task automatic chk_zero(input string nm);
        chk({nm, "_busy"}, bus.busy, 0);
        chk({nm, "_done"}, bus.done, 0);
        chk({nm, "_mm"}, bus.mismatch, 0);
        chk({nm, "_pass"}, bus.pass_count, 0);
        chk({nm, "_fail"}, bus.fail_count, 0);
        chk({nm, "_ffv"}, bus.first_fail_valid, 0);
        chk({nm, "_ffi"}, bus.first_fail_idx, 0);
    endtask
    initial begin
        tab = '{32'h0, 32'h1, 32'h2, 32'h4, 32'h5, 32'h7, 32'h8, 32'hb,
                32'h3, 32'hfffffffe, 32'h10, 32'h14, 32'hffffffff, 32'h1c, 32'h20, 32'h40,
                32'hdeadbeef, 32'h12345678, 32'h80000000, 32'h7fffffff, 32'h55, 32'haa, 32'h100, 32'hfffffff0,
                32'h1234, 32'h64, 32'hfffffb2c, 32'h30, 32'h30, 32'ha5a5a5a5, 32'h5a5a5a5a, 32'hcafef00d};
        bus.load_en = 0; bus.load_addr = 0; bus.load_data = 0; bus.load_mask = 0;
        bus.num_checks = 0; bus.start = 0; bus.result_valid = 0; bus.result = 0;
        repeat (2) @(negedge clk);
        chk_zero("reset");
        reset = 1'b0;
        for (int i = 0; i < 32; i++) load(i, tab[i], 32'hffffffff);
        // full pass
        exp_sum(29, 0, 0, 0);
        go(29);
        for (int i = 0; i < 29; i++) sample(tab[i], 0, i == 28);
        wait_done();
        // two mismatches
        exp_sum(27, 2, 1, 9);
        go(29);
        for (int i = 0; i < 29; i++)
            sample(i == 9 ? 32'hfffffffd : i == 13 ? 32'h0 : tab[i], i == 9 || i == 13, i == 28);
        wait_done();
        // masked low byte on entry 3
        load(3, 32'h4, 32'hffffff00);
        exp_sum(4, 0, 0, 0);
        go(4);
        for (int i = 0; i < 4; i++) sample(i == 3 ? 32'h7f : tab[i], 0, i == 3);
        wait_done();
        load(3, 32'h4, 32'hffffffff);
        exp_sum(3, 1, 1, 3);
        go(4);
        for (int i = 0; i < 4; i++) sample(i == 3 ? 32'h7f : tab[i], i == 3, i == 3);
        wait_done();
        // bubbles with illegal start/load mid-run
        exp_sum(29, 0, 0, 0);
        go(29);
        for (int i = 0; i < 29; i++) begin
            sample(tab[i], 0, i == 28);
            if (i != 28) begin
                bus.result = 32'hbad0bad0;
                if (i == 5) begin
                    bus.start = 1; bus.num_checks = 3;
                    bus.load_en = 1; bus.load_addr = 20; bus.load_data = 0; bus.load_mask = 32'hffffffff;
                end
                @(negedge clk);
                bus.start = 0; bus.load_en = 0;
            end
        end
        wait_done();
        // N=0 from DONE
        go(0);
        chk("n0_done", bus.done, 1);
        chk("n0_busy", bus.busy, 0);
        chk("n0_pass", bus.pass_count, 0);
        chk("n0_fail", bus.fail_count, 0);
        chk("n0_ffv", bus.first_fail_valid, 0);
        // N clamped to DEPTH; extra samples after done are ignored
        exp_sum(32, 0, 0, 0);
        go(40);
        for (int i = 0; i < 32; i++) sample(tab[i], 0, i == 31);
        bus.result_valid = 1; bus.result = 32'h1;
        repeat (2) @(negedge clk);
        bus.result_valid = 0;
        chk("clamp_pass_hold", bus.pass_count, 32);
        chk("clamp_fail_hold", bus.fail_count, 0);
        // reset mid-run, then table survives
        go(29);
        for (int i = 0; i < 10; i++) sample(i == 4 ? 32'h77 : tab[i], i == 4, 0);
        reset = 1'b1;
        @(negedge clk);
        chk_zero("midrun_reset");
        reset = 1'b0;
        exp_sum(29, 0, 0, 0);
        go(29);
        for (int i = 0; i < 29; i++) sample(tab[i], 0, i == 28);
        wait_done();
        repeat (3) @(negedge clk);
        chk("sample_queue_drained", mm_q.size(), 0);
        chk("summary_queue_drained", sum_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/result_scoreboard.md
# result_scoreboard

Parametrised, synthesizable result checker for the single-cycle RISC-V processor. It holds a loadable table of expected values with per-entry compare masks. It compares a stream of processor results against the table in order and accumulates pass/fail counts and the index of the first failure. It replaces hand-timed, fixed-delay result checking: comparison is gated by a valid strobe, so stalls and bubbles are tolerated and the same block serves any program length up to DEPTH.

## Interface
- WIDTH, 32: result and expected-value width.
- DEPTH, 32: expected-table entries (≥2). IDX_W = $clog2(DEPTH), derived.
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- load_en  in  1  write expected table entry.
- load_addr  in  IDX_W  table address.
- load_data  in  WIDTH  expected value.
- load_mask  in  WIDTH  compare mask; bit=1 means compared, 0 means don't-care.
- num_checks  in  IDX_W+1  entries to check, latched on start.
- start  in  1  begin a check run.
- result_valid  in  1  result is a checkable sample this cycle.
- result  in  WIDTH  processor result (e.g. ALU/writeback Result).
- busy  out  1  RUN state.
- done  out  1  run complete; held.
- pass_count  out  IDX_W+1  matching samples.
- fail_count  out  IDX_W+1  mismatching samples.
- first_fail_valid  out  1  at least one mismatch this run.
- first_fail_idx  out  IDX_W  table index of first mismatch.
- mismatch  out  1  registered one-cycle pulse per failing sample.

## Operation
- States: IDLE, RUN, DONE. Reset value: IDLE.
- IDLE/DONE + start: latch N = min(num_checks, DEPTH). Clear pass_count, fail_count, first_fail_valid, first_fail_idx, done, and internal index idx=0.
  - N=0: go to DONE.
  - Otherwise: go to RUN.
- RUN + result_valid: compare ((result ^ exp[idx]) & mask[idx]) == 0.
  - Match: pass_count+1.
  - Mismatch: fail_count+1 and mismatch=1. If first_fail_valid=0, set it and capture first_fail_idx=idx.
  - Then idx+1.
  - If idx == N-1, go to DONE.
- RUN without result_valid: hold all state.
- start while busy: ignored.
- load_en: writes exp/mask[load_addr] only in IDLE or DONE; ignored in RUN, so the table is protected during a run.
- Simultaneous load_en and start: the write lands on the same edge. The first compare cannot occur before the next edge, so it uses the new value.
- DONE: done=1 and all counts held until start or reset.
- Counts cannot overflow: max value N ≤ DEPTH fits in IDX_W+1 bits.
- Reset, in any state including mid-RUN: state IDLE.
  - busy, done, mismatch, pass_count, fail_count, first_fail_valid and first_fail_idx all go to 0.
  - Table contents are NOT cleared and survive reset.

## Timing
- start sampled at edge k: busy=1 from edge k (0 if N=0; in that case done=1 from edge k).
- Sample at edge m: counts, first_fail fields and mismatch are visible after edge m, i.e. one-cycle latency.
- mismatch is high for exactly the cycle after a failing edge.
- Last sample (idx=N-1) at edge m: done=1 and busy=0 after edge m, in the same cycle the final counts appear.
- result_valid is ignored in IDLE and DONE.
- Back-to-back samples: one compare per cycle, no stall.
- Table read is combinational on idx (register file or distributed RAM).

## Test plan
- Full pass: load 29 entries (0,1,2,4,5,7,8,0xb,3,0xfffffffe,…,0xfffffb2c,0x30,0x30) with mask 0xFFFFFFFF, N=29, feed matching results every cycle -> done one cycle after the 29th sample, pass=29, fail=0, first_fail_valid=0, mismatch never high.
- Mismatch: same table, result 0xfffffffd at idx 9 and 0x0 at idx 13 -> pass=27, fail=2, first_fail_idx=9, mismatch pulses exactly twice, one cycle after each failing edge.
- Mask: entry 3 expected 0x04 with mask 0xFFFFFF00, result 0x7F -> pass; with mask 0xFFFFFFFF -> fail.
- Bubbles and illegal controls: result_valid every other cycle -> same counts as the full-pass case, done 28 cycles later. start and load_en pulsed mid-RUN -> no effect on the run or the table.
- Bounds: num_checks=0 -> done=1 after the start edge, busy never 1, counts 0. num_checks=40 -> exactly 32 samples consumed.
- Reset mid-RUN after 10 samples -> the next cycle shows all outputs 0 and the block in IDLE. A restart with N=29 then gives pass=29, confirming the table was preserved.
